// File: rtl/rng_calib_seq.sv
// rtl/rng_calib_seq.sv - RNG-driven conf1/conf0 field calibration sequencer
// Optional accepted-sample budget enabled by defining RNG_CALIB_TIMEOUT_EN.
module rng_calib_seq #(
  parameter int NUM_KNOBS = 3,
  parameter int CONF_W    = 4,
  parameter int CONF1_MIN = 0,
  parameter int CONF0_MAX = 2**CONF_W-1,
  parameter int CONF1_RST = 2**CONF_W-1,
  parameter int CONF0_RST = 0,
  parameter int MAX_STEPS = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        rng_bit,
  input  logic                        rng_valid,
  output logic                        rng_ready,
  output logic [NUM_KNOBS*CONF_W-1:0] conf1,
  output logic [NUM_KNOBS*CONF_W-1:0] conf0,
  output logic [2:0]                  knob_idx,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_KNOBS-1:0]        sat,
  output logic                        timeout
);

  localparam logic [CONF_W-1:0] C1_MIN   = CONF_W'(CONF1_MIN);
  localparam logic [CONF_W-1:0] C0_MAX   = CONF_W'(CONF0_MAX);
  localparam logic [CONF_W-1:0] C1_RST   = CONF_W'(CONF1_RST);
  localparam logic [CONF_W-1:0] C0_RST   = CONF_W'(CONF0_RST);
  localparam logic [2:0]        LAST_IDX = 3'(NUM_KNOBS-1);

  typedef enum logic [3:0] {
    IDLE, WAIT_START, CHK1, DEC1, CHK0, INC0, WAIT_BIT, NEXT, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CONF_W-1:0] cur1, cur0;
  logic              accept, budget_hit;
  logic              run_start, do_dec1, do_inc0, set_sat, idx_adv;

  assign cur1      = conf1[knob_idx*CONF_W +: CONF_W];
  assign cur0      = conf0[knob_idx*CONF_W +: CONF_W];
  assign rng_ready = (state == WAIT_START) || (state == WAIT_BIT);
  assign accept    = rng_valid && rng_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

`ifdef RNG_CALIB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_STEPS+1);
  logic [CNT_W-1:0] step_cnt;

  // The acceptance that brings the count up to MAX_STEPS ends the run.
  assign budget_hit = accept && (step_cnt == CNT_W'(MAX_STEPS-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
      timeout  <= 1'b0;
    end else if (run_start) begin
      step_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (accept)
        step_cnt <= step_cnt + CNT_W'(1);
      if (budget_hit)
        timeout <= 1'b1;
    end
  end
`else
  assign budget_hit = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    run_start = 1'b0;
    do_dec1   = 1'b0;
    do_inc0   = 1'b0;
    set_sat   = 1'b0;
    idx_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT_START;
          run_start = 1'b1;
        end
      end
      WAIT_START: if (accept) state_nxt = rng_bit ? CHK1 : DONE;
      CHK1:       state_nxt = (cur1 == C1_MIN) ? CHK0 : DEC1;
      DEC1: begin
        do_dec1   = 1'b1;
        state_nxt = WAIT_BIT;
      end
      CHK0: begin
        if (cur0 == C0_MAX) begin
          set_sat   = 1'b1;
          state_nxt = NEXT;
        end else begin
          state_nxt = INC0;
        end
      end
      INC0: begin
        do_inc0   = 1'b1;
        state_nxt = WAIT_BIT;
      end
      WAIT_BIT: if (accept) state_nxt = rng_bit ? CHK1 : NEXT;
      NEXT: begin
        if (knob_idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_adv   = 1'b1;
          state_nxt = CHK1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (budget_hit)
      state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      knob_idx <= '0;
      sat      <= '0;
      conf1    <= {NUM_KNOBS{C1_RST}};
      conf0    <= {NUM_KNOBS{C0_RST}};
    end else begin
      state <= state_nxt;
      if (run_start) begin
        knob_idx <= '0;
        sat      <= '0;
      end
      if (idx_adv)
        knob_idx <= knob_idx + 3'd1;
      // Only the selected field pair is touched; bounds are re-checked here.
      for (int k = 0; k < NUM_KNOBS; k++) begin
        if (3'(k) == knob_idx) begin
          if (do_dec1 && (cur1 != C1_MIN))
            conf1[k*CONF_W +: CONF_W] <= cur1 - CONF_W'(1);
          if (do_inc0 && (cur0 != C0_MAX))
            conf0[k*CONF_W +: CONF_W] <= cur0 + CONF_W'(1);
          if (set_sat)
            sat[k] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rng_calib_seq.sv
// tb/tb_rng_calib_seq.sv - table-driven scoreboard bench for rng_calib_seq
// Build with RNG_CALIB_TIMEOUT_EN defined to exercise the step budget (MAX_STEPS=8).
module tb_rng_calib_seq;

  localparam int NK = 3;
  localparam int CW = 4;
`ifdef RNG_CALIB_TIMEOUT_EN
  localparam int STEPS = 8;
`else
  localparam int STEPS = 64;
`endif

  logic               clk = 1'b0;
  logic               reset, start, rng_bit, rng_valid;
  logic               rng_ready, busy, done, timeout;
  logic [NK*CW-1:0]   conf1, conf0;
  logic [2:0]         knob_idx;
  logic [NK-1:0]      sat;

  rng_calib_seq #(.NUM_KNOBS(NK), .CONF_W(CW), .MAX_STEPS(STEPS)) dut (
    .clk(clk), .reset(reset), .start(start), .rng_bit(rng_bit),
    .rng_valid(rng_valid), .rng_ready(rng_ready), .conf1(conf1),
    .conf0(conf0), .knob_idx(knob_idx), .busy(busy), .done(done),
    .sat(sat), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic        tail;
    logic [11:0] exp_c1;
    logic [11:0] exp_c0;
    logic [2:0]  exp_sat;
    logic        exp_to;
    int          exp_acc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] bits, input int nbits, input logic tail,
                         input logic [11:0] c1, input logic [11:0] c0,
                         input logic [2:0] s, input logic to, input int acc);
    vec_t v;
    v = '{bits, nbits, tail, c1, c0, s, to, acc};
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; rng_valid = 1'b0; rng_bit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   n = 0;
    bit   seen = 0;
    vec_t e;
    do_reset();
    sb.push_back(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      if (done) begin
        seen = 1;
        rng_valid = 1'b0;
        e = sb.pop_front();
        check($sformatf("v%0d_conf1", id), conf1, e.exp_c1);
        check($sformatf("v%0d_conf0", id), conf0, e.exp_c0);
        check($sformatf("v%0d_sat", id), sat, e.exp_sat);
        check($sformatf("v%0d_timeout", id), timeout, e.exp_to);
        check($sformatf("v%0d_accepted", id), n, e.exp_acc);
      end else begin
        rng_valid = rng_ready && ($urandom_range(0, 3) != 0);
        if (rng_valid) begin
          rng_bit = (n < v.nbits) ? v.bits[n] : v.tail;
          n++;
        end else begin
          rng_bit = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL v%0d_done: got no done pulse expected one within budget", id);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", id), {busy, done}, 2'b00);
      @(negedge clk);
      check($sformatf("v%0d_conf1_hold", id), conf1, v.exp_c1);
    end
  endtask

  initial begin
    bit stall_ok;
    bit done_seen;
    reset = 1'b1; start = 1'b0; rng_valid = 1'b0; rng_bit = 1'b0;

`ifdef RNG_CALIB_TIMEOUT_EN
    add_vec(32'h0,       1,  1'b0, 12'hFFF, 12'h000, 3'b000, 1'b0, 1);
    add_vec(32'h3,       5,  1'b0, 12'hEED, 12'h000, 3'b000, 1'b0, 5);
    add_vec(32'h1,       1,  1'b0, 12'hEEE, 12'h000, 3'b000, 1'b0, 4);
    add_vec(32'h0,       0,  1'b1, 12'hFF8, 12'h000, 3'b000, 1'b1, 8);
`else
    add_vec(32'h0,       1,  1'b0, 12'hFFF, 12'h000, 3'b000, 1'b0, 1);
    add_vec(32'h3,       5,  1'b0, 12'hEED, 12'h000, 3'b000, 1'b0, 5);
    add_vec(32'h1,       1,  1'b0, 12'hEEE, 12'h000, 3'b000, 1'b0, 4);
    add_vec(32'h0,       0,  1'b1, 12'h000, 12'hFFF, 3'b111, 1'b0, 91);
    add_vec(32'h1FFFF,   17, 1'b0, 12'hEE0, 12'h002, 3'b000, 1'b0, 20);
    add_vec(32'h7FFFFFFF, 31, 1'b0, 12'hEE0, 12'h00F, 3'b001, 1'b0, 33);
`endif

    do_reset();
    check("rst_conf1", conf1, 12'hFFF);
    check("rst_conf0", conf0, 12'h000);
    check("rst_sat", sat, 3'b000);
    check("rst_timeout", timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", rng_ready, 1'b0);
    check("rst_knob", knob_idx, 3'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Stall in WAIT_BIT with stray start and bit noise, then reset mid-run.
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rng_valid = 1'b1;
    rng_bit = 1'b1;
    @(negedge clk);
    rng_valid = 1'b0;
    for (int i = 0; i < 10 && !rng_ready; i++) @(negedge clk);
    check("stall_ready", rng_ready, 1'b1);
    check("stall_conf1_entry", conf1, 12'hFFE);
    stall_ok = 1;
    for (int i = 0; i < 10; i++) begin
      rng_bit = 1'($urandom);
      start = (i == 3);
      @(negedge clk);
      if (conf1 !== 12'hFFE || conf0 !== 12'h000 || knob_idx !== 3'd0 ||
          rng_ready !== 1'b1 || done !== 1'b0)
        stall_ok = 0;
    end
    start = 1'b0;
    check("stall_frozen", stall_ok, 1'b1);
    reset = 1'b1; start = 1'b1; rng_valid = 1'b1; rng_bit = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; rng_valid = 1'b0;
    check("midrst_conf1", conf1, 12'hFFF);
    check("midrst_conf0", conf0, 12'h000);
    check("midrst_busy", busy, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_seen = 1;
      @(negedge clk);
    end
    check("midrst_no_done", done_seen, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
